// File: rtl/array_pkg.sv
// Shared types and constants for the row-array issue/capture stage.
package array_pkg;

   localparam int unsigned ARR_WIDTH  = 4;
   localparam int unsigned SETTLE_MAX = 15;
   localparam int unsigned SETTLE_W   = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      DONE   = 2'd2
   } state_e;

endpackage

// File: rtl/array_issue_ctrl.sv
// Issue/capture stage for the external combinational row array: holds one operand
// pair on arr_a/arr_b for a fixed settle time, captures arr_r and hands it downstream.
module array_issue_ctrl
   import array_pkg::*;
#(
   parameter int unsigned WIDTH      = ARR_WIDTH,
   parameter int unsigned SETTLE_CYC = 2,
   parameter int unsigned CNT_W      = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic [WIDTH-1:0] arr_a,
   output logic [WIDTH-1:0] arr_b,
   input  logic [WIDTH-1:0] arr_r,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_r,
   output logic             busy,
   output logic [CNT_W-1:0] op_count
);

   // Out-of-range settle values are clamped into 1..SETTLE_MAX.
   localparam int unsigned SETTLE_EFF = (SETTLE_CYC < 1) ? 1 :
                                        (SETTLE_CYC > SETTLE_MAX) ? SETTLE_MAX : SETTLE_CYC;
   localparam logic [SETTLE_W-1:0] CNT_LOAD = SETTLE_W'(SETTLE_EFF - 1);

   state_e              r_state;
   logic [SETTLE_W-1:0] r_cnt;
   logic [WIDTH-1:0]    r_arr_a;
   logic [WIDTH-1:0]    r_arr_b;
   logic [WIDTH-1:0]    r_out_r;
   logic                r_out_valid;
   logic                r_busy;
   logic [CNT_W-1:0]    r_op_count;
   logic                w_accept;

   // Ready is independent of in_valid; DONE can hand off and accept on the same edge.
   assign in_ready = (r_state == IDLE) | ((r_state == DONE) & out_ready);
   assign w_accept = in_valid & in_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_arr_a     <= '0;
         r_arr_b     <= '0;
         r_out_r     <= '0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_op_count  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_arr_a <= in_a;
                  r_arr_b <= in_b;
                  r_cnt   <= CNT_LOAD;
                  r_busy  <= 1'b1;
                  r_state <= SETTLE;
               end
            end
            SETTLE: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - SETTLE_W'(1);
               end else begin
                  r_out_r     <= arr_r;
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_op_count  <= r_op_count + CNT_W'(1);
                  r_out_valid <= 1'b0;
                  if (w_accept) begin
                     r_arr_a <= in_a;
                     r_arr_b <= in_b;
                     r_cnt   <= CNT_LOAD;
                     r_state <= SETTLE;
                  end else begin
                     r_busy  <= 1'b0;
                     r_state <= IDLE;
                  end
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
               r_state     <= IDLE;
            end
         endcase
      end
   end

   assign arr_a     = r_arr_a;
   assign arr_b     = r_arr_b;
   assign out_r     = r_out_r;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;
   assign op_count  = r_op_count;

endmodule

// File: tb/tb_array_issue_ctrl.sv
// Scoreboard bench for array_issue_ctrl: directed scenarios followed by random traffic,
// with a second instance (2-bit counter) riding on the same stimulus.
module tb_array_issue_ctrl;

   localparam int unsigned W      = 4;
   localparam int unsigned S      = 2;
   localparam int unsigned N_RAND = 300;

   logic         clk       = 1'b0;
   logic         reset     = 1'b1;
   logic         in_valid  = 1'b0;
   logic [W-1:0] in_a      = '0;
   logic [W-1:0] in_b      = '0;
   logic         out_ready = 1'b0;
   logic         rand_ready = 1'b0;

   logic         in_ready,  in_ready2;
   logic [W-1:0] arr_a, arr_b, arr_r, arr_a2, arr_b2, arr_r2;
   logic         out_valid, out_valid2;
   logic [W-1:0] out_r, out_r2;
   logic         busy, busy2;
   logic [7:0]   op_count;
   logic [1:0]   op_count2;

   int n_tests = 0;
   int n_fail  = 0;

   logic [W-1:0] exp_q[$];

   always #5 clk = ~clk;

   array_issue_ctrl #(.WIDTH(W), .SETTLE_CYC(S), .CNT_W(8)) u_dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .arr_a(arr_a), .arr_b(arr_b), .arr_r(arr_r),
      .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r),
      .busy(busy), .op_count(op_count)
   );

   array_issue_ctrl #(.WIDTH(W), .SETTLE_CYC(S), .CNT_W(2)) u_dut2 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
      .in_a(in_a), .in_b(in_b), .arr_a(arr_a2), .arr_b(arr_b2), .arr_r(arr_r2),
      .out_valid(out_valid2), .out_ready(out_ready), .out_r(out_r2),
      .busy(busy2), .op_count(op_count2)
   );

   // Behavioural row array: low nibble of a*b + a, valid only once its inputs
   // have been steady long enough; before that it shows the inverted value.
   function automatic logic [W-1:0] arr_model(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [2*W-1:0] p;
      p = {4'b0, a} * {4'b0, b};
      return p[W-1:0] + a;
   endfunction

   logic [2*W-1:0] last_ab = '0;
   int unsigned    stab    = 0;
   always @(negedge clk) begin
      if ({arr_a, arr_b} !== last_ab) begin
         last_ab <= {arr_a, arr_b};
         stab    <= 0;
      end else if (stab < 100) begin
         stab <= stab + 1;
      end
   end
   assign arr_r  = (stab >= S - 1) ? arr_model(arr_a, arr_b)   : ~arr_model(arr_a, arr_b);
   assign arr_r2 = (stab >= S - 1) ? arr_model(arr_a2, arr_b2) : ~arr_model(arr_a2, arr_b2);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
   endtask

   // Present a pair until accepted; the expected result goes on the scoreboard.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
      int waited = 0;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      #1;
      while (!in_ready && waited < 64) begin
         tick();
         #1;
         waited++;
      end
      if (!in_ready) begin
         chk("accept_wait", 32'(in_ready), 32'd1);
         in_valid = 1'b0;
         return;
      end
      exp_q.push_back(arr_model(a, b));
      tick();
      in_valid = 1'b0;
   endtask

   // Monitor: reference model of occupancy, latency, counters and results.
   int unsigned  inflight = 0;
   int unsigned  age      = 0;
   int           cnt_ops  = 0;
   logic [W-1:0] last_a   = '0;
   logic [W-1:0] last_b   = '0;

   always @(negedge clk) begin : monitor
      logic ov_exp;
      logic hs;
      logic acc;
      #2;
      ov_exp = (inflight != 0) && (age >= S);
      chk("out_valid",  32'(out_valid),  32'(ov_exp));
      chk("out_valid2", 32'(out_valid2), 32'(ov_exp));
      chk("busy",       32'(busy),       32'(inflight != 0));
      chk("in_ready",   32'(in_ready),   32'((inflight == 0) || (ov_exp && out_ready)));
      chk("in_ready2",  32'(in_ready2),  32'((inflight == 0) || (ov_exp && out_ready)));
      chk("arr_a",      32'(arr_a),      32'(last_a));
      chk("arr_b",      32'(arr_b),      32'(last_b));
      chk("op_count",   32'(op_count),   32'(cnt_ops % 256));
      chk("op_count2",  32'(op_count2),  32'(cnt_ops % 4));
      if (ov_exp && exp_q.size() != 0) begin
         chk("out_r",  32'(out_r),  32'(exp_q[0]));
         chk("out_r2", 32'(out_r2), 32'(exp_q[0]));
      end
      if (reset) begin
         inflight = 0;
         age      = 0;
         cnt_ops  = 0;
         last_a   = '0;
         last_b   = '0;
         exp_q.delete();
      end else begin
         hs  = ov_exp && out_ready;
         acc = in_valid && ((inflight == 0) || hs);
         if (hs) begin
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            inflight = inflight - 1;
            cnt_ops  = cnt_ops + 1;
         end
         if (acc) begin
            inflight = inflight + 1;
            age      = 0;
            last_a   = in_a;
            last_b   = in_b;
         end else if (age < 1000) begin
            age = age + 1;
         end
      end
   end

   initial begin
      repeat (3) tick();
      reset = 1'b0;
      repeat (5) tick();

      out_ready = 1'b1;
      send(4'h3, 4'h5);
      repeat (S + 2) tick();

      // Backpressure: result must sit untouched in DONE.
      out_ready = 1'b0;
      send(4'h9, 4'h6);
      repeat (S + 6) tick();
      out_ready = 1'b1;
      repeat (3) tick();

      send(4'h1, 4'h1);
      send(4'hF, 4'hF);
      send(4'h8, 4'h7);
      send(4'h0, 4'hA);
      repeat (S + 2) tick();

      // Reset in the middle of SETTLE drops the operation.
      send(4'hC, 4'h3);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      repeat (S + 3) tick();

      rand_ready = 1'b1;
      for (int i = 0; i < N_RAND; i++) begin
         repeat ($urandom_range(0, 2)) tick();
         send(W'($urandom), W'($urandom));
      end
      rand_ready = 1'b0;
      out_ready  = 1'b1;
      for (int i = 0; i < 64 && exp_q.size() != 0; i++) tick();
      if (exp_q.size() != 0) chk("drain", 32'(exp_q.size()), 32'd0);
      repeat (2) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, %0d pending results", exp_q.size());
      $fatal(1);
   end

endmodule
